decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 10 +
 rtl/decoder_core.sv | 20 ++
 rtl/decoder.sv | 46 ++++
 tb/tb_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared widths and types for the 4-to-16 one-hot decoder.
package decoder_pkg;

  localparam int DEC_IN_W  = 4;
  localparam int DEC_OUT_W = 2 ** DEC_IN_W;

  typedef logic [DEC_IN_W-1:0]  dec_sel_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage : decoder_pkg

// File: rtl/decoder_core.sv
// Pure combinational enable + select to one-hot decode; no clock, no state.
module decoder_core
  import decoder_pkg::*;
(
  input  dec_sel_t    sel,
  input  logic        enable,
  output dec_onehot_t onehot
);

  // A shift by an X/Z amount yields all-X in simulation, so a bad select
  // is never masked as a plausible one-hot code.
  // NOTE: onehot gets a default before the branch so no path can infer a latch.
  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot = dec_onehot_t'(1) << sel;
    end
  end

endmodule : decoder_core

// File: rtl/decoder.sv
// One-hot decoder top with an optional one-cycle registered copy of the output.
// Define DECODER_REG_OUT_EN to build the registered path; otherwise it is tied to 0.
module decoder
  import decoder_pkg::*;
#(
  parameter  int IN_W  = DEC_IN_W,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  binary_in,
  input  logic             enable,
  output logic [OUT_W-1:0] decoder_out,
  output logic [OUT_W-1:0] decoder_out_q,
  output logic             out_valid
);

  dec_onehot_t core_onehot;

  decoder_core u_core (
    .sel    (dec_sel_t'(binary_in)),
    .enable (enable),
    .onehot (core_onehot)
  );

  assign decoder_out = OUT_W'(core_onehot);

`ifdef DECODER_REG_OUT_EN
  // decoder_out is already zero whenever enable is low, so the registered
  // copy is zero in every cycle where out_valid is low.
  // NOTE: non-blocking assignments keep both flops sampling the same edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decoder_out_q <= '0;
      out_valid     <= 1'b0;
    end else begin
      decoder_out_q <= decoder_out;
      out_valid     <= enable;
    end
  end
`else
  assign decoder_out_q = '0;
  assign out_valid     = 1'b0;
`endif

endmodule : decoder

// File: tb/tb_decoder.sv
// Directed, table-driven bench for decoder; adapts its register expectations
// to whether DECODER_REG_OUT_EN is defined.
module tb_decoder;

`ifdef DECODER_REG_OUT_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  binary_in;
  logic        enable;
  logic [15:0] decoder_out;
  logic [15:0] decoder_out_q;
  logic        out_valid;

  int tests_run;
  int tests_failed;

  decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .binary_in     (binary_in),
    .enable        (enable),
    .decoder_out   (decoder_out),
    .decoder_out_q (decoder_out_q),
    .out_valid     (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Sweep 1..15 enabled, then disabled corners including all-ones select.
    for (int i = 1; i < 16; i++) begin
      vec_t v;
      v.sel = 4'(i);
      v.en = 1'b1;
      v.exp_out = 16'h0001 << i;
      vecs.push_back(v);
    end
    vecs.push_back('{4'b1111, 1'b0, 16'h0000});
    vecs.push_back('{4'b0000, 1'b0, 16'h0000});
    vecs.push_back('{4'b0101, 1'b0, 16'h0000});
    vecs.push_back('{4'b0101, 1'b1, 16'h0020});
    vecs.push_back('{4'b1010, 1'b1, 16'h0400});

    rst_n     = 1'b0;
    binary_in = 4'b0000;
    enable    = 1'b0;
    #3;
    check("reset_q",     decoder_out_q, 16'h0000);
    check("reset_valid", {15'd0, out_valid}, 16'h0000);

    // Combinational path must work while reset is still held.
    binary_in = 4'b0110;
    enable    = 1'b1;
    #1;
    check("out_in_reset", decoder_out, 16'h0040);
    enable = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      binary_in = vecs[i].sel;
      enable    = vecs[i].en;
      #10;
      check($sformatf("vec%0d_out", i), decoder_out, vecs[i].exp_out);
    end

    // Select 0 enabled, then drop enable without changing select.
    binary_in = 4'b0000;
    enable    = 1'b1;
    #1;
    check("sel0_en", decoder_out, 16'h0001);
    enable = 1'b0;
    #1;
    check("sel0_dis", decoder_out, 16'h0000);

    // Registered path: one clean disabled edge so the registers start at zero.
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    binary_in = 4'b0011;
    enable    = 1'b1;
    #1;
    check("pre_edge_q",     decoder_out_q, 16'h0000);
    check("pre_edge_valid", {15'd0, out_valid}, 16'h0000);
    @(posedge clk);
    #1;
    check("post_edge_q",     decoder_out_q, REG_EN ? 16'h0008 : 16'h0000);
    check("post_edge_valid", {15'd0, out_valid}, {15'd0, REG_EN});

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_pulse_q",     decoder_out_q, 16'h0000);
    check("rst_pulse_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_pulse_out",   decoder_out, 16'h0008);
    rst_n = 1'b1;
    #1;
    check("rst_rel_q", decoder_out_q, 16'h0000);
    @(posedge clk);
    #1;
    check("first_edge_q",     decoder_out_q, REG_EN ? 16'h0008 : 16'h0000);
    check("first_edge_valid", {15'd0, out_valid}, {15'd0, REG_EN});

    // Change select; registered copy follows one edge later.
    @(negedge clk);
    binary_in = 4'b1111;
    #1;
    check("lag_q", decoder_out_q, REG_EN ? 16'h0008 : 16'h0000);
    @(posedge clk);
    #1;
    check("lag_next_q", decoder_out_q, REG_EN ? 16'h8000 : 16'h0000);

    // Disabling clears both registered outputs on the next edge.
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("dis_q",     decoder_out_q, 16'h0000);
    check("dis_valid", {15'd0, out_valid}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_decoder
